// File: rtl/encoder_sweep_capture_if.sv
// Bus bundle between the sweep/capture stage and the encoder under test.
// The master side is the sweep stage; the slave side is the encoder plus
// whatever drives start and reads the result table.
interface encoder_sweep_capture_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 4
);
   logic              start_i;
   logic [N_IN-1:0]   operand_a_o;
   logic [N_OUT-1:0]  result_i;
   logic              busy_o;
   logic              done_o;
   logic              collision_o;
   logic [15:0]       signature_o;
   logic [N_IN-1:0]   rd_addr_i;
   logic [N_OUT-1:0]  rd_data_o;

   modport master (
      input  start_i, result_i, rd_addr_i,
      output operand_a_o, busy_o, done_o, collision_o, signature_o, rd_data_o
   );

   modport slave (
      output start_i, result_i, rd_addr_i,
      input  operand_a_o, busy_o, done_o, collision_o, signature_o, rd_data_o
   );
endinterface

// File: rtl/encoder_sweep_capture.sv
// Exhaustive sweep driver for a registered encoder: issues every input code
// once, captures each result into a per-code table, folds the results into a
// 16-bit MISR signature and flags codes that map onto the same result.
module encoder_sweep_capture #(
   parameter int          N_IN      = 4,
   parameter int          N_OUT     = 4,
   parameter int          LATENCY   = 1,
   parameter logic [15:0] MISR_POLY = 16'hB400
) (
   input logic                   clk_ci,
   input logic                   rst_i,
   encoder_sweep_capture_if.master bus
);
   localparam int DEPTH  = 1 << N_IN;
   localparam int SEEN_N = 1 << N_OUT;
   localparam logic [N_IN-1:0] LAST_CODE = {N_IN{1'b1}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]        state;
   logic [N_IN-1:0]   operand;
   logic              trk_vld_p  [LATENCY];
   logic [N_IN-1:0]   trk_code_p [LATENCY];
   logic [N_OUT-1:0]  mem        [DEPTH];
   logic [SEEN_N-1:0] seen;
   logic              collision;
   logic [15:0]       signature;
   logic [N_OUT-1:0]  rd_data;

   logic              start_ok;
   logic              capture;
   logic [N_IN-1:0]   head_code;

   // Results wider than 16 bits are folded by XOR-ing their 16-bit slices;
   // narrower results simply zero-extend.
   function automatic logic [15:0] fold16(input logic [N_OUT-1:0] r);
      logic [15:0] f;
      f = '0;
      for (int i = 0; i < N_OUT; i++) f[i % 16] = f[i % 16] ^ r[i];
      return f;
   endfunction

   function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [N_OUT-1:0] r);
      return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ fold16(r);
   endfunction

   assign start_ok  = bus.start_i && (state == ST_IDLE || state == ST_DONE);
   assign capture   = trk_vld_p[LATENCY-1];
   assign head_code = trk_code_p[LATENCY-1];

   // Sequencer: walks the codes in unsigned order, then waits for the last capture.
   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         operand <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start_i) begin
                  state   <= ST_SWEEP;
                  operand <= '0;
               end
            end
            ST_SWEEP: begin
               if (operand == LAST_CODE) begin
                  state   <= ST_DRAIN;
                  operand <= '0;
               end else begin
                  operand <= operand + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (capture && head_code == LAST_CODE) state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Alignment pipe: the head pairs result_i with the code that produced it.
   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            trk_vld_p[i]  <= 1'b0;
            trk_code_p[i] <= '0;
         end
      end else begin
         trk_vld_p[0]  <= (state == ST_SWEEP);
         trk_code_p[0] <= operand;
         for (int i = 1; i < LATENCY; i++) begin
            trk_vld_p[i]  <= trk_vld_p[i-1];
            trk_code_p[i] <= trk_code_p[i-1];
         end
      end
   end

   // Result table: overwritten by each sweep, only reset clears it.
   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (capture) begin
         mem[head_code] <= bus.result_i;
      end
   end

   // Signature and injectivity tracking, re-armed by every accepted start.
   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) begin
         signature <= '0;
         seen      <= '0;
         collision <= 1'b0;
      end else if (start_ok) begin
         signature <= '0;
         seen      <= '0;
         collision <= 1'b0;
      end else if (capture) begin
         signature <= misr_next(signature, bus.result_i);
         if (seen[bus.result_i]) collision <= 1'b1;
         seen[bus.result_i] <= 1'b1;
      end
   end

   // Registered read port; a same-cycle capture to the addressed entry shows next cycle.
   always_ff @(posedge clk_ci or posedge rst_i) begin
      if (rst_i) rd_data <= '0;
      else       rd_data <= mem[bus.rd_addr_i];
   end

   assign bus.operand_a_o = operand;
   assign bus.busy_o      = (state == ST_SWEEP) || (state == ST_DRAIN);
   assign bus.done_o      = (state == ST_DONE);
   assign bus.collision_o = collision;
   assign bus.signature_o = signature;
   assign bus.rd_data_o   = rd_data;
endmodule

// File: tb/tb_encoder_sweep_capture.sv
// Bench for encoder_sweep_capture: a LATENCY=1 instance fed by a selectable
// bench encoder and a LATENCY=2 instance fed by a two-stage identity encoder.
module tb_encoder_sweep_capture;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] mode = 2'd0;  // 0 identity, 1 constant 5, 2 identity with code 3 -> 2

   int n_tests = 0;
   int n_fail  = 0;

   encoder_sweep_capture_if #(.N_IN(4), .N_OUT(4)) bus1 ();
   encoder_sweep_capture_if #(.N_IN(4), .N_OUT(4)) bus2 ();

   encoder_sweep_capture #(.N_IN(4), .N_OUT(4), .LATENCY(1), .MISR_POLY(16'hB400)) dut1 (
      .clk_ci(clk), .rst_i(rst), .bus(bus1));
   encoder_sweep_capture #(.N_IN(4), .N_OUT(4), .LATENCY(2), .MISR_POLY(16'hB400)) dut2 (
      .clk_ci(clk), .rst_i(rst), .bus(bus2));

   always #5 clk = ~clk;

   function automatic logic [3:0] enc(input logic [1:0] m, input logic [3:0] code);
      if (m == 2'd1) return 4'h5;
      if (m == 2'd2 && code == 4'd3) return 4'd2;
      return code;
   endfunction

   // Reference MISR over the whole expected result sequence of a run.
   function automatic logic [15:0] ref_sig(input logic [1:0] m);
      logic [15:0] s;
      logic fb;
      s = 16'h0;
      for (int k = 0; k < 16; k++) begin
         fb = s[15];
         s  = s << 1;
         if (fb) s = s ^ 16'hB400;
         s = s ^ {12'h000, enc(m, 4'(k))};
      end
      return s;
   endfunction

   // Bench encoders: one register for dut1, two for dut2.
   logic [3:0] d2 = 4'h0;
   always @(posedge clk) bus1.result_i <= enc(mode, bus1.operand_a_o);
   always @(posedge clk) begin
      d2 <= bus2.operand_a_o;
      bus2.result_i <= d2;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ne(input string name, input logic [31:0] a, input logic [31:0] b);
      n_tests++;
      if (a === b) begin
         n_fail++;
         $display("FAIL %s: both %0h, expected different", name, a);
      end
   endtask

   task automatic rd(input logic [3:0] a, output logic [3:0] q1, output logic [3:0] q2);
      bus1.rd_addr_i = a;
      bus2.rd_addr_i = a;
      tick();
      q1 = bus1.rd_data_o;
      q2 = bus2.rd_data_o;
   endtask

   // Results recorded by run_sweep (cycle c = period after start edge + c - 1).
   int busy1_n, busy2_n, done1_at, done2_at, coll_at;
   logic [3:0] op8, rd7, rd8;
   logic [15:0] sig_c1;
   logic coll_c1, done_held;

   task automatic run_sweep(input logic [1:0] m, input bit hold);
      mode = m;
      bus1.rd_addr_i = 4'd4;
      bus2.rd_addr_i = 4'd4;
      bus1.start_i = 1'b1;
      bus2.start_i = 1'b1;
      tick();
      busy1_n = 0; busy2_n = 0; done1_at = 0; done2_at = 0; coll_at = 0;
      for (int c = 1; c <= 40; c++) begin
         if (bus1.busy_o) busy1_n++;
         if (bus2.busy_o) busy2_n++;
         if (bus1.done_o && done1_at == 0) done1_at = c;
         if (bus2.done_o && done2_at == 0) done2_at = c;
         if (bus1.collision_o && coll_at == 0) coll_at = c;
         if (c == 1) begin
            sig_c1  = bus1.signature_o;
            coll_c1 = bus1.collision_o;
         end
         if (c == 7) rd7 = bus1.rd_data_o;
         if (c == 8) begin
            rd8 = bus1.rd_data_o;
            op8 = bus1.operand_a_o;
         end
         bus1.start_i = hold && (done1_at == 0);
         bus2.start_i = bus1.start_i;
         if (done1_at != 0 && done2_at != 0) break;
         tick();
      end
      bus1.start_i = 1'b0;
      bus2.start_i = 1'b0;
      tick();
      done_held = bus1.done_o && bus2.done_o;
   endtask

   typedef struct {
      logic [1:0] mode;
      logic       exp_coll;
      logic [3:0] addr;
      logic [3:0] exp_data;
   } vec_t;

   initial begin
      vec_t vecs[$];
      logic [3:0] q1, q2;
      logic [1:0] cur;
      logic [15:0] ident_sig;

      vecs.push_back('{2'd2, 1'b1, 4'd3,  4'd2});
      vecs.push_back('{2'd2, 1'b1, 4'd2,  4'd2});
      vecs.push_back('{2'd2, 1'b1, 4'd4,  4'd4});
      vecs.push_back('{2'd1, 1'b1, 4'd0,  4'd5});
      vecs.push_back('{2'd1, 1'b1, 4'd8,  4'd5});
      vecs.push_back('{2'd1, 1'b1, 4'd15, 4'd5});
      vecs.push_back('{2'd0, 1'b0, 4'd7,  4'd7});
      vecs.push_back('{2'd0, 1'b0, 4'd12, 4'd12});

      bus1.start_i = 1'b0; bus2.start_i = 1'b0;
      bus1.rd_addr_i = 4'd0; bus2.rd_addr_i = 4'd0;
      #2;
      chk("rst operand", bus1.operand_a_o, 0);
      chk("rst busy", bus1.busy_o, 0);
      chk("rst done", bus1.done_o, 0);
      chk("rst collision", bus1.collision_o, 0);
      chk("rst signature", bus1.signature_o, 0);
      chk("rst rd_data", bus1.rd_data_o, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Identity run on both instances.
      run_sweep(2'd0, 1'b0);
      chk("id busy cycles", busy1_n, 17);
      chk("id done cycle", done1_at, 18);
      chk("id operand at cycle 8", op8, 7);
      chk("id done held", done_held, 1);
      chk("id collision", bus1.collision_o, 0);
      chk("id signature", bus1.signature_o, ref_sig(2'd0));
      chk("lat2 busy cycles", busy2_n, 18);
      chk("lat2 done cycle", done2_at, 19);
      chk("lat2 collision", bus2.collision_o, 0);
      chk("lat2 signature", bus2.signature_o, ref_sig(2'd0));
      ident_sig = bus1.signature_o;
      for (int i = 0; i < 16; i++) begin
         rd(4'(i), q1, q2);
         chk($sformatf("id table[%0d]", i), q1, i);
         chk($sformatf("lat2 table[%0d]", i), q2, i);
      end

      // Vector table: one run per mode change, then collision and table reads.
      cur = 2'd3;
      foreach (vecs[j]) begin
         if (vecs[j].mode != cur) begin
            cur = vecs[j].mode;
            run_sweep(cur, 1'b0);
            chk($sformatf("mode%0d done cycle", cur), done1_at, 18);
            chk($sformatf("mode%0d signature", cur), bus1.signature_o, ref_sig(cur));
            if (cur == 2'd2) chk_ne("flipped bit changes signature", bus1.signature_o, ident_sig);
         end
         chk($sformatf("vec%0d collision", j), bus1.collision_o, vecs[j].exp_coll);
         rd(vecs[j].addr, q1, q2);
         chk($sformatf("vec%0d table[%0d]", j, vecs[j].addr), q1, vecs[j].exp_data);
      end

      // Constant run: collision appears one cycle after the second capture.
      run_sweep(2'd1, 1'b0);
      chk("const collision cycle", coll_at, 4);
      chk("const collision final", bus1.collision_o, 1);
      // Restart from DONE clears collision/signature; read sees old value on write cycle.
      run_sweep(2'd0, 1'b0);
      chk("restart collision cleared", coll_c1, 0);
      chk("restart signature cleared", sig_c1, 0);
      chk("read during write old", rd7, 5);
      chk("read after write new", rd8, 4);
      chk("repeat run signature", bus1.signature_o, ident_sig);

      // start_i held high through the sweep does not restart it.
      run_sweep(2'd0, 1'b1);
      chk("held start busy cycles", busy1_n, 17);
      chk("held start done cycle", done1_at, 18);
      chk("held start done held", done_held, 1);
      chk("held start signature", bus1.signature_o, ident_sig);

      // Asynchronous reset in the middle of a sweep.
      mode = 2'd0;
      bus1.rd_addr_i = 4'd4; bus2.rd_addr_i = 4'd4;
      bus1.start_i = 1'b1; bus2.start_i = 1'b1;
      tick();
      bus1.start_i = 1'b0; bus2.start_i = 1'b0;
      for (int c = 0; c < 20 && bus1.operand_a_o != 4'd7; c++) tick();
      chk("midrun operand reached 7", bus1.operand_a_o, 7);
      chk("midrun rd_data before reset", bus1.rd_data_o, 4);
      rst = 1'b1;
      #1;
      chk("async rst operand", bus1.operand_a_o, 0);
      chk("async rst busy", bus1.busy_o, 0);
      chk("async rst done", bus1.done_o, 0);
      chk("async rst collision", bus1.collision_o, 0);
      chk("async rst signature", bus1.signature_o, 0);
      chk("async rst rd_data", bus1.rd_data_o, 0);
      tick();
      rst = 1'b0;
      rd(4'd3, q1, q2);
      chk("post rst table[3]", q1, 0);
      rd(4'd12, q1, q2);
      chk("post rst table[12]", q1, 0);
      chk("post rst lat2 table[12]", q2, 0);
      run_sweep(2'd0, 1'b0);
      chk("post rst done cycle", done1_at, 18);
      chk("post rst signature", bus1.signature_o, ref_sig(2'd0));
      rd(4'd9, q1, q2);
      chk("post rst run table[9]", q1, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
